seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Unsigned sequential restoring divider, the inverse operation of the ALU's combinational
//  array multiplier. Computes quotient and remainder of dividend/divisor, one quotient bit
//  per clock, behind a start/busy/done handshake. Sits beside the multiplier as the ALU's
//  DIV/MOD unit; the ALU result mux reads quotient/remainder on done.
// PARAMETERS
//  WIDTH  4  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  rst_n        in   1      reset: synchronous, active-low
//  start        in   1      request; sampled only while idle (busy=0)
//  dividend     in   WIDTH  numerator, captured on the accepting edge
//  divisor      in   WIDTH  denominator, captured on the accepting edge
//  busy         out  1      1 while a division is in progress
//  done         out  1      one-cycle pulse: quotient/remainder/div_by_zero valid
//  quotient     out  WIDTH  registered result; holds until next accepted start
//  remainder    out  WIDTH  registered result; holds until next accepted start
//  div_by_zero  out  1      registered; 1 iff captured divisor was 0
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, busy=0, done=0, quotient=0, remainder=0,
//    div_by_zero=0, counter=0. Applies mid-operation; in-flight division discarded, no done.
//  - FSM: IDLE -> RUN on edge with start=1; RUN -> IDLE on edge where counter==0.
//  - Accept edge E: latch dividend into shift reg Q, divisor into D, partial remainder
//    R (WIDTH+1 bits) := 0, counter := WIDTH-1, busy := 1, div_by_zero := (divisor==0).
//  - Each RUN edge: T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D} (WIDTH+1 bits);
//    if no borrow: R := T, shift 1 into Q LSB; else R := {R[WIDTH-1:0],Q[MSB]}, shift 0.
//    Q shifts left each step; counter decrements.
//  - Final step at edge E+WIDTH: quotient := Q, remainder := R[WIDTH-1:0], done := 1,
//    busy := 0, state IDLE. done is 0 on every other cycle. Latency = WIDTH cycles.
//  - start while busy=1 is ignored (operands not re-captured, no queueing).
//  - start=1 in the cycle done=1 (state already IDLE) is accepted: back-to-back ops,
//    throughput one result per WIDTH+1 cycles.
//  - Divide by zero: no special datapath; algorithm naturally yields quotient=all ones,
//    remainder=dividend; div_by_zero=1 for that op. Same latency as normal op.
//  - quotient/remainder/div_by_zero change only at reset, accept (flag), and final step.
//  - Invariant for divisor!=0: dividend == quotient*divisor + remainder, remainder<divisor.
// STRUCTURE
//  - Shared package: FSM state encoding (S_IDLE, S_RUN), counter width $clog2(WIDTH).
//  - Sub-module div_sub_stage: (WIDTH+1)-bit ripple borrow subtractor built from
//    full-subtractor gates; outputs difference and borrow_out. One instance, combinational.
//  - Top holds FSM, counter, Q/R/D registers, output registers.
// TESTING (WIDTH=4)
//  - 13/3: start at edge E -> done=1 after edge E+4, quotient=4, remainder=1, dbz=0.
//  - 15/1 -> quotient=15, remainder=0; 2/9 -> quotient=0, remainder=2.
//  - 7/0 -> quotient=15, remainder=7, div_by_zero=1, done after 4 cycles.
//  - start pulsed with 9/2 at E+2 during 13/3 run -> ignored; result 4 r1 unchanged.
//  - rst_n=0 at edge E+2 of a run -> next cycle busy=0, outputs 0; no done pulse ever.
//  - start held high across done: 13/3 then 12/5 -> done twice, 5 cycles apart, 2 r2.
//  - Random sweep all 256 operand pairs: check invariant and done count == accepts.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the helper that sizes the step counter from the operand width.
package seq_divider_pkg;

  // Controller states: waiting for a request, or stepping through quotient bits.
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Step counter width: must hold WIDTH-1, and never collapse below one bit.
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the ALU front end (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_sub_stage.sv
// One trial-subtraction stage of the divider: an N-bit ripple-borrow
// subtractor built from full-subtractor cells. borrow_out=1 means a < b.
module div_sub_stage #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] borrow_s;

  assign borrow_s[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_fs
    // Full-subtractor cell: difference bit and borrow into the next position.
    assign diff[i]       = a[i] ^ b[i] ^ borrow_s[i];
    assign borrow_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_s[i]);
  end

  assign borrow_out = borrow_s[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Results are held until the next accepted start.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;          // captured divisor
  logic [WIDTH:0]   r_q, r_d;          // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             accept_s;
  logic             last_s;
  logic [WIDTH:0]   sub_a_s;
  logic [WIDTH:0]   sub_b_s;
  logic [WIDTH:0]   diff_s;
  logic             borrow_s;
  logic [WIDTH:0]   r_step_s;
  logic [WIDTH-1:0] q_step_s;
  // Only the low WIDTH bits of R feed the next step; the MSB is kept for
  // a faithful WIDTH+1-bit partial remainder but is never consumed.
  logic             unused_r_msb_s;

  assign unused_r_msb_s = r_q[WIDTH];

  assign accept_s = (state_q == S_IDLE) && bus.start;
  assign last_s   = (state_q == S_RUN) && (cnt_q == CNT_ZERO);

  // Trial subtraction: shifted remainder with next dividend bit, minus divisor.
  assign sub_a_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign sub_b_s = {1'b0, d_q};

  div_sub_stage #(
    .N(WIDTH + 1)
  ) u_sub (
    .a          (sub_a_s),
    .b          (sub_b_s),
    .diff       (diff_s),
    .borrow_out (borrow_s)
  );

  // Restore on borrow (keep the shifted value), otherwise take the difference.
  assign r_step_s = borrow_s ? sub_a_s : diff_s;
  assign q_step_s = {q_q[WIDTH-2:0], ~borrow_s};

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept only while idle, finish when the counter hits zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, one step per RUN cycle, publish on the last.
  always_comb begin
    q_d    = q_q;
    d_d    = d_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    if (accept_s) begin
      q_d   = bus.dividend;
      d_d   = bus.divisor;
      r_d   = {(WIDTH + 1){1'b0}};
      cnt_d = CNT_LAST;
      dbz_d = (bus.divisor == {WIDTH{1'b0}});
    end else if (state_q == S_RUN) begin
      q_d = q_step_s;
      r_d = r_step_s;
      if (last_s) begin
        cnt_d  = CNT_ZERO;
        quot_d = q_step_s;
        rem_d  = r_step_s[WIDTH-1:0];
        done_d = 1'b1;
      end else begin
        cnt_d  = cnt_q - {{(CW - 1){1'b0}}, 1'b1};
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Datapath and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= {WIDTH{1'b0}};
      d_q    <= {WIDTH{1'b0}};
      r_q    <= {(WIDTH + 1){1'b0}};
      cnt_q  <= CNT_ZERO;
      quot_q <= {WIDTH{1'b0}};
      rem_q  <= {WIDTH{1'b0}};
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      d_q    <= d_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  // Outputs come straight from flops; busy is the RUN state itself.
  always_comb begin
    bus.busy        = (state_q == S_RUN);
    bus.done        = done_q;
    bus.quotient    = quot_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_divider;

  localparam int W = 4;

  typedef struct {
    int dvd;
    int dvs;
    int done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   dones;
  int   expected_dones;
  exp_t exp_q[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    int   eq, er, ed;
    if (bus.done === 1'b1) begin
      dones++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        e  = exp_q.pop_front();
        eq = (e.dvs == 0) ? (1 << W) - 1 : e.dvd / e.dvs;
        er = (e.dvs == 0) ? e.dvd : e.dvd % e.dvs;
        ed = (e.dvs == 0) ? 1 : 0;
        check($sformatf("quotient %0d/%0d", e.dvd, e.dvs), int'(bus.quotient), eq);
        check($sformatf("remainder %0d/%0d", e.dvd, e.dvs), int'(bus.remainder), er);
        check($sformatf("dbz %0d/%0d", e.dvd, e.dvs), int'(bus.div_by_zero), ed);
        check($sformatf("latency %0d/%0d", e.dvd, e.dvs), cyc, e.done_cyc);
        if (e.dvs != 0) begin
          check($sformatf("invariant %0d/%0d", e.dvd, e.dvs),
                int'(bus.quotient) * e.dvs + int'(bus.remainder), e.dvd);
        end
      end
    end
  end

  // Wait (bounded) for idle, then present one request for a single accepting edge.
  task automatic do_op(input int dvd, input int dvs);
    int   guard;
    exp_t e;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 1, 0);
    bus.start    = 1'b1;
    bus.dividend = dvd[W-1:0];
    bus.divisor  = dvs[W-1:0];
    e.dvd      = dvd;
    e.dvs      = dvs;
    e.done_cyc = cyc + 1 + W;
    exp_q.push_back(e);
    expected_dones++;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Wait (bounded) until every outstanding request has produced its result.
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int   idx[256];
    int   tmp, j;
    exp_t e;
    int   cyc0;
    vectors        = 0;
    miscompares    = 0;
    dones          = 0;
    expected_dones = 0;
    cyc            = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (2) @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset quotient", int'(bus.quotient), 0);
    check("reset remainder", int'(bus.remainder), 0);
    check("reset dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operand patterns, including divide by zero.
    do_op(13, 3); drain();
    do_op(15, 1); drain();
    do_op(2, 9);  drain();
    do_op(7, 0);  drain();

    // A start pulse during a run must be ignored.
    do_op(13, 3);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd2;
    check("busy during run", int'(bus.busy), 1);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset in the middle of a run discards it and clears the results.
    do_op(7, 2);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    expected_dones--;
    @(negedge clk);
    check("midreset busy", int'(bus.busy), 0);
    check("midreset done", int'(bus.done), 0);
    check("midreset quotient", int'(bus.quotient), 0);
    check("midreset remainder", int'(bus.remainder), 0);
    check("midreset dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);

    // Start held high across done: two results, W+1 cycles apart.
    cyc0         = cyc;
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    e.dvd = 13; e.dvs = 3; e.done_cyc = cyc0 + 1 + W;
    exp_q.push_back(e);
    e.dvd = 12; e.dvs = 5; e.done_cyc = cyc0 + 2 + 2 * W;
    exp_q.push_back(e);
    expected_dones += 2;
    @(negedge clk);
    bus.dividend = 4'd12;
    bus.divisor  = 4'd5;
    repeat (W) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Every operand pair in random order, with random gaps (0 = back-to-back).
    for (int i = 0; i < 256; i++) idx[i] = i;
    for (int i = 255; i > 0; i--) begin
      j      = $urandom_range(i, 0);
      tmp    = idx[i];
      idx[i] = idx[j];
      idx[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      do_op(idx[i] / 16, idx[i] % 16);
    end
    drain();
    repeat (W + 2) @(negedge clk);
    check("done count", dones, expected_dones);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
